// File: rtl/game_score_tracker.sv
// Match score tracker: counts round wins/losses from an upstream counter and latches a result.
// Optional STREAK_BONUS_EN macro adds a 2-bit win-streak bonus (third consecutive win adds 2).
module game_score_tracker #(
  parameter int WINS_TO_MATCH   = 3,
  parameter int LOSSES_TO_MATCH = 3,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             winner,
  input  logic             loser,
  output logic             ctr_rst,
  output logic [CNT_W-1:0] win_count,
  output logic [CNT_W-1:0] lose_count,
  output logic             gameover,
  output logic             who
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [CNT_W+1:0] CNT_MAX  = {2'b00, {CNT_W{1'b1}}};
  localparam logic [31:0]      WIN_LIM  = WINS_TO_MATCH;
  localparam logic [31:0]      LOSE_LIM = LOSSES_TO_MATCH;

  state_t           state;
  logic             winner_prev;
  logic             loser_prev;
  logic             win_event;
  logic             loss_event;
  logic [1:0]       win_inc;
  logic [CNT_W-1:0] win_next;
  logic [CNT_W-1:0] lose_next;
  logic             win_done;
  logic             lose_done;

  // Saturating add so counts stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, a} + {{CNT_W{1'b0}}, inc};
    if (sum > CNT_MAX) return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

`ifdef STREAK_BONUS_EN
  logic [1:0] streak;
  assign win_inc = (streak == 2'd2) ? 2'd2 : 2'd1;
`else
  assign win_inc = 2'd1;
`endif

  assign win_event  = winner & ~winner_prev;
  assign loss_event = loser & ~loser_prev;
  assign ctr_rst    = (state != PLAY);

  always_comb begin
    win_next  = sat_add(win_count, win_inc);
    lose_next = sat_add(lose_count, 2'd1);
    win_done  = (32'(win_next) >= WIN_LIM);
    lose_done = (32'(lose_next) >= LOSE_LIM);
  end

  // Edge detectors run in every state so a level held across entry into PLAY never counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      win_count   <= '0;
      lose_count  <= '0;
      gameover    <= 1'b0;
      who         <= 1'b0;
      winner_prev <= 1'b0;
      loser_prev  <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak      <= 2'd0;
`endif
    end else begin
      winner_prev <= winner;
      loser_prev  <= loser;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= PLAY;
            win_count  <= '0;
            lose_count <= '0;
`ifdef STREAK_BONUS_EN
            streak     <= 2'd0;
`endif
          end
        end
        PLAY: begin
          if (start) begin
            win_count  <= '0;
            lose_count <= '0;
`ifdef STREAK_BONUS_EN
            streak     <= 2'd0;
`endif
          end else if (win_event && !loss_event) begin
            win_count <= win_next;
`ifdef STREAK_BONUS_EN
            streak    <= (streak == 2'd2) ? 2'd0 : streak + 2'd1;
`endif
            if (win_done) begin
              state    <= OVER;
              gameover <= 1'b1;
              who      <= 1'b1;
            end
          end else if (loss_event && !win_event) begin
            lose_count <= lose_next;
`ifdef STREAK_BONUS_EN
            streak     <= 2'd0;
`endif
            if (lose_done) begin
              state    <= OVER;
              gameover <= 1'b1;
              who      <= 1'b0;
            end
          end
        end
        OVER: begin
          if (start) begin
            state      <= PLAY;
            win_count  <= '0;
            lose_count <= '0;
            gameover   <= 1'b0;
            who        <= 1'b0;
`ifdef STREAK_BONUS_EN
            streak     <= 2'd0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_score_tracker.sv
// Self-checking bench for game_score_tracker: directed scenarios plus randomized play against a behavioural model.
module tb_game_score_tracker;

  localparam int CNT_W = 4;
  localparam int LOSSES = 3;
`ifdef STREAK_BONUS_EN
  localparam int WINS = 5;
`else
  localparam int WINS = 3;
`endif
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, start, winner, loser;
  logic             ctr_rst, gameover, who;
  logic [CNT_W-1:0] win_count, lose_count;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: phase 0=idle, 1=playing, 2=result held
  int m_phase = 0, m_win = 0, m_lose = 0, m_streak = 0;
  bit m_go = 0, m_who = 0, m_wprev = 0, m_lprev = 0;

  game_score_tracker #(
    .WINS_TO_MATCH(WINS), .LOSSES_TO_MATCH(LOSSES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .winner(winner), .loser(loser),
    .ctr_rst(ctr_rst), .win_count(win_count), .lose_count(lose_count),
    .gameover(gameover), .who(who)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(posedge clk) begin
    bit w_rise, l_rise;
    int inc;
    w_rise = winner && !m_wprev;
    l_rise = loser && !m_lprev;
    if (rst) begin
      m_phase = 0; m_win = 0; m_lose = 0; m_streak = 0;
      m_go = 0; m_who = 0; m_wprev = 0; m_lprev = 0;
    end else begin
      if (m_phase == 1 && !start && w_rise && !l_rise) begin
        inc = 1;
`ifdef STREAK_BONUS_EN
        m_streak = m_streak + 1;
        if (m_streak == 3) begin
          inc = 2;
          m_streak = 0;
        end
`endif
        m_win = sat(m_win + inc);
        if (m_win >= WINS) begin m_phase = 2; m_go = 1; m_who = 1; end
      end else if (m_phase == 1 && !start && l_rise && !w_rise) begin
        m_lose = sat(m_lose + 1);
        m_streak = 0;
        if (m_lose >= LOSSES) begin m_phase = 2; m_go = 1; m_who = 0; end
      end else if (start) begin
        m_phase = 1; m_win = 0; m_lose = 0; m_streak = 0; m_go = 0; m_who = 0;
      end
      m_wprev = winner;
      m_lprev = loser;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model ctr_rst", int'(ctr_rst), int'(m_phase != 1));
      checkOutput("model win_count", int'(win_count), m_win);
      checkOutput("model lose_count", int'(lose_count), m_lose);
      checkOutput("model gameover", int'(gameover), int'(m_go));
      if (m_go) checkOutput("model who", int'(who), int'(m_who));
    end
  end

  // Drives inputs, lets one rising edge sample them, returns shortly after it.
  task automatic applyStimulus(input bit r, input bit s, input bit w, input bit l);
    rst = r; start = s; winner = w; loser = l;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; winner = 1'b0; loser = 1'b0;
    applyStimulus(1, 0, 0, 0);
    chk_en = 1'b1;
    checkOutput("reset ctr_rst", int'(ctr_rst), 1);
    checkOutput("reset win_count", int'(win_count), 0);
    checkOutput("reset gameover", int'(gameover), 0);

    // Reset mid-match with two wins counted
    applyStimulus(0, 1, 0, 0);
    checkOutput("start ctr_rst", int'(ctr_rst), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("first win", int'(win_count), 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("second win", int'(win_count), 2);
    applyStimulus(1, 0, 0, 0);
    checkOutput("midreset win_count", int'(win_count), 0);
    checkOutput("midreset gameover", int'(gameover), 0);
    checkOutput("midreset ctr_rst", int'(ctr_rst), 1);

    applyStimulus(0, 1, 0, 0);
`ifdef STREAK_BONUS_EN
    applyStimulus(0, 0, 1, 0); checkOutput("streak w1", int'(win_count), 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0); checkOutput("streak w2", int'(win_count), 2);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0); checkOutput("streak w3 bonus", int'(win_count), 4);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1); checkOutput("streak loss", int'(lose_count), 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("streak final win", int'(win_count), 5);
    checkOutput("streak gameover", int'(gameover), 1);
    checkOutput("streak who", int'(who), 1);
`else
    applyStimulus(0, 0, 1, 0); checkOutput("match w1", int'(win_count), 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0); checkOutput("match w2", int'(win_count), 2);
    checkOutput("match w2 gameover", int'(gameover), 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("match w3", int'(win_count), 3);
    checkOutput("match gameover", int'(gameover), 1);
    checkOutput("match who", int'(who), 1);
    checkOutput("match ctr_rst", int'(ctr_rst), 1);
`endif

    // Held winner level counts once
    applyStimulus(0, 1, 0, 0);
    checkOutput("restart win_count", int'(win_count), 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("held win", int'(win_count), 1);

    // Simultaneous rise ignored, then a loss
    applyStimulus(0, 0, 1, 1);
    checkOutput("both win_count", int'(win_count), 1);
    checkOutput("both lose_count", int'(lose_count), 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("loss after both", int'(lose_count), 1);

    // Lose the match, events ignored in result, then restart
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("lost lose_count", int'(lose_count), 3);
    checkOutput("lost gameover", int'(gameover), 1);
    checkOutput("lost who", int'(who), 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("over hold lose_count", int'(lose_count), 3);
    checkOutput("over hold who", int'(who), 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("replay lose_count", int'(lose_count), 0);
    checkOutput("replay gameover", int'(gameover), 0);
    checkOutput("replay ctr_rst", int'(ctr_rst), 0);

    // Randomized play
    begin
      bit w, l;
      w = 0; l = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 2) == 0) w = ~w;
        if ($urandom_range(0, 2) == 0) l = ~l;
        applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0, w, l);
      end
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_score_tracker.md
GAME_SCORE_TRACKER -- requirements
Module: game_score_tracker

Interface
REQ-001 Parameter WINS_TO_MATCH, default 3: counted wins that end a match with who=1.
REQ-002 Parameter LOSSES_TO_MATCH, default 3: counted losses that end a match with who=0.
REQ-003 Parameter CNT_W, default 4: width of win_count/lose_count.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: level; begins or restarts a match.
REQ-007 Port winner, input, 1: round-won indication from the upstream counter; pulse or held level.
REQ-008 Port loser, input, 1: round-lost indication from the upstream counter; pulse or held level.
REQ-009 Port ctr_rst, output, 1: drives the upstream counter's rst; holds it cleared outside play.
REQ-010 Port win_count, output, CNT_W: counted wins in the current match.
REQ-011 Port lose_count, output, CNT_W: counted losses in the current match.
REQ-012 Port gameover, output, 1: high while a match result is held.
REQ-013 Port who, output, 1: match result; 1=player won, 0=player lost; valid only while gameover=1.

Function
REQ-014 The block SHALL implement FSM states IDLE, PLAY and OVER.
REQ-015 IDLE->PLAY on start=1; counts cleared on that same edge.
REQ-016 PLAY with start=1 SHALL clear both counts and stay in PLAY; the restart overrides any event sampled that cycle.
REQ-017 OVER->PLAY on start=1; counts cleared, who and gameover cleared on that same edge.
REQ-018 ctr_rst SHALL be combinational: 1 when the state is not PLAY, 0 in PLAY.
REQ-019 winner_prev/loser_prev registers SHALL sample winner/loser every cycle in every state.
REQ-020 A win event is winner=1 with winner_prev=0, sampled in PLAY; a loss event is defined likewise on loser.
- A held level SHALL count once.
- A level already high when PLAY is entered SHALL NOT count.
REQ-021 A win event alone SHALL increment win_count; a loss event alone SHALL increment lose_count.
- The new count is visible the cycle after the sampling edge (latency 1).
REQ-022 Simultaneous win and loss events SHALL be ignored (no count change, no streak change).
REQ-023 Counts SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 On the edge where the updated win_count >= WINS_TO_MATCH, the state SHALL become OVER with who=1 and gameover=1.
- The loss check is symmetric: lose_count >= LOSSES_TO_MATCH gives who=0.
- gameover rises in the same cycle as the final count.
REQ-025 In OVER, counts, who and gameover SHALL hold; winner/loser events SHALL be ignored.

Reset
REQ-026 On rst=1 at a clock edge:
- State becomes IDLE.
- win_count, lose_count, gameover, who, winner_prev, loser_prev and the streak count all become 0.
- ctr_rst becomes 1.
REQ-027 rst SHALL take priority over start and events in every state, including mid-match.
REQ-028 Before the first clock edge with rst=1, output values are undefined.

Configuration
REQ-029 Macro STREAK_BONUS_EN, when defined, SHALL add a 2-bit streak counter:
- A counted win increments the streak; a counted loss or a restart clears it.
- The third consecutive counted win adds 2 to win_count (saturating) and clears the streak.
- The match-end check of REQ-024 uses the bonus-updated win_count.
REQ-030 With STREAK_BONUS_EN undefined, no streak logic SHALL exist and every counted win adds exactly 1.

Verification
REQ-031 rst=1 during PLAY with win_count=2 -> next cycle: IDLE, counts 0, gameover=0, ctr_rst=1.
REQ-032 start pulse, then winner pulses on 3 separate cycles (no macro) -> win_count 1,2,3; gameover=1 and who=1 with count 3; ctr_rst=1.
REQ-033 winner held high for 5 cycles in PLAY -> win_count increments by exactly 1.
REQ-034 winner and loser both rise in the same cycle -> counts unchanged; a subsequent loser-only pulse -> lose_count=1.
REQ-035 In OVER (who=0, lose_count=3), loser pulses -> no change; start=1 -> PLAY, counts 0, gameover=0, ctr_rst=0.
REQ-036 With STREAK_BONUS_EN and WINS_TO_MATCH=5: wins W,W,W -> win_count 1,2,4; then L, W -> lose_count=1, win_count=5, gameover=1, who=1.
